multi_key_monitor: RTL and testbench
====================================

Name: multi_key_monitor

Overview:
Parametrised multi-channel successor to the single-key edge monitor for the digital lock keypad. It takes NUM_KEYS raw push-button inputs and synchronises each one, applies a polarity fix and debounces it. Per key it emits a one-cycle press pulse and a one-cycle release pulse, plus a debounced level. A registered "any press" strobe with the index of the lowest pressed key feeds the lock's code-entry FSM directly.

Parameters:
NUM_KEYS, 4, number of independent key channels (>=1)
DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a level change (>=1; 1 = no filtering)
SYNC_STAGES, 2, synchroniser flop depth per key (>=2)
KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (board push-buttons); 0 = active-high

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
key  input  NUM_KEYS  raw asynchronous button inputs
keyState  output  NUM_KEYS  debounced level per key, 1 = pressed
keyEdge  output  NUM_KEYS  one-cycle pulse per key on an accepted press
keyRelease  output  NUM_KEYS  one-cycle pulse per key on an accepted release
keyValid  output  1  one-cycle pulse, high whenever any keyEdge bit is high
keyCode  output  KEY_CODE_WIDTH  index of the lowest-numbered key in keyEdge; valid only while keyValid=1

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: keyState, keyEdge, keyRelease, keyValid and keyCode are all 0.
  - Synchroniser flops reset to the inactive raw level: 1 if KEY_ACTIVE_LOW, else 0.
  - Debounce counters reset to 0.
- Synchroniser: SYNC_STAGES-deep flop chain per key, then a polarity normalise. After that stage, 1 always means pressed.
- Debounce, per channel: stable register S and counter C, width clog2(DEBOUNCE_CYCLES+1).
  - Synced sample == S: C <= 0.
  - Sample != S and C < DEBOUNCE_CYCLES-1: C <= C+1.
  - Sample != S and C == DEBOUNCE_CYCLES-1: S <= sample, C <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes S.
- Pulses: keyEdge[i] and keyRelease[i] are registered.
  - They are high exactly in the cycle after the edge at which S flips 0->1 (keyEdge) or 1->0 (keyRelease).
  - Each is high for one cycle only and never both at once.
  - keyState = S.
- Latency: a clean raw change sampled at edge 0 is visible on keyState, keyEdge and keyRelease after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is edge 6.
- keyValid/keyCode: registered on the same edge as keyEdge.
  - keyCode is the lowest set index of the keyEdge vector.
  - When keyValid=0, keyCode = 0.
- Simultaneous presses in one cycle: all matching keyEdge bits are set; keyValid=1; keyCode = lowest index.
- Releases never assert keyValid.
- Held key: no repeat pulses; keyEdge fires once per accepted press.
- Reset mid-operation: all state is cleared on the next edge and no pulse is emitted while reset=1. A key held through reset is accepted as a fresh press after the full latency from reset deassertion.
- KEY_CODE_WIDTH = max(1, clog2(NUM_KEYS)), so NUM_KEYS=1 gives a 1-bit keyCode that is always 0.

Decomposition:
- Package key_monitor_pkg holds:
  - constant function clog2 and a max helper;
  - the KEY_CODE_WIDTH and counter-width derivations.
- Sub-module key_debounce_channel: synchroniser, polarity fix, debounce counter and edge/release pulse generation for one key.
  - Parameters: DEBOUNCE_CYCLES, SYNC_STAGES, KEY_ACTIVE_LOW.
  - The top instantiates NUM_KEYS copies via generate and adds the registered priority encoder for keyValid/keyCode.

Test Plan:
(defaults: NUM_KEYS=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, KEY_ACTIVE_LOW=1)
1. Reset: reset=1 for 2 cycles, key=4'b1111 -> keyState=0, keyEdge=0, keyRelease=0, keyValid=0, keyCode=0 throughout.
2. Press: key=4'b1101 held for 10 cycles -> at edge 6, keyEdge=4'b0010 for exactly 1 cycle, keyValid=1, keyCode=1; keyState=4'b0010 from then on.
3. Bounce: key[0]=0 for 3 cycles, then 1 -> no keyEdge and keyState unchanged. Then key[0]=0 held for 8 cycles -> keyEdge=4'b0001 once, keyCode=0.
4. Simultaneous: key[3:2] go low on the same cycle -> keyEdge=4'b1100 for 1 cycle, keyValid=1, keyCode=2.
5. Release: key[1] returns to 1 after test 2 -> keyRelease=4'b0010 for 1 cycle at edge 6, keyState[1]=0, keyValid stays 0.
6. Reset mid-debounce: key[3]=0; reset=1 for 1 cycle after 3 edges -> no pulse at all. Key still held -> keyEdge=4'b1000 exactly 6 edges after reset deasserts.

Source files
------------

// File: rtl/key_monitor_pkg.sv
// Shared helpers and width derivations for the multi-key monitor.
// Imported by the channel, the interface users and the top.
package key_monitor_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1)
      r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int code_width(input int n);
    return max2(1, clog2(n));
  endfunction

  function automatic int cnt_width(input int d);
    return max2(1, clog2(d + 1));
  endfunction

endpackage

// File: rtl/multi_key_monitor_if.sv
// Key inputs and debounced outputs of the multi-key monitor.
// master = monitor side, slave = keypad/FSM side.
interface multi_key_monitor_if #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W   = 2
);

  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] keyState;
  logic [NUM_KEYS-1:0] keyEdge;
  logic [NUM_KEYS-1:0] keyRelease;
  logic                keyValid;
  logic [CODE_W-1:0]   keyCode;

  modport master (
    input  key,
    output keyState,
    output keyEdge,
    output keyRelease,
    output keyValid,
    output keyCode
  );

  modport slave (
    output key,
    input  keyState,
    input  keyEdge,
    input  keyRelease,
    input  keyValid,
    input  keyCode
  );

endinterface

// File: rtl/key_debounce_channel.sv
// One key: synchroniser, polarity fix, debounce counter and
// registered press/release pulses.
module key_debounce_channel
  import key_monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic state,
  output logic press,
  output logic rel,
  output logic press_next
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic IDLE = (KEY_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   stable_q;
  logic [CW-1:0]          cnt_q;
  logic                   rel_next;

  always_ff @(posedge clock) begin
    if (reset)
      sync_q <= {SYNC_STAGES{IDLE}};
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], key};
  end

  // XOR with the idle level makes 1 mean pressed
  assign sample = sync_q[SYNC_STAGES-1] ^ IDLE;

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (sample == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      stable_q <= sample;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign press_next = stable_q & ~state;
  assign rel_next   = ~stable_q & state;

  // state lags stable_q by one edge so it moves with the pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= stable_q;
      press <= press_next;
      rel   <= rel_next;
    end
  end

endmodule

// File: rtl/multi_key_monitor.sv
// NUM_KEYS debounced key channels plus a registered
// lowest-index press encoder for the code-entry FSM.
module multi_key_monitor
  import key_monitor_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  multi_key_monitor_if.master  bus
);

  localparam int CODE_W = code_width(NUM_KEYS);

  logic [NUM_KEYS-1:0] state_v;
  logic [NUM_KEYS-1:0] press_v;
  logic [NUM_KEYS-1:0] rel_v;
  logic [NUM_KEYS-1:0] rise_v;
  logic [CODE_W-1:0]   code_next;
  logic                valid_q;
  logic [CODE_W-1:0]   code_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .key        (bus.key[g]),
      .state      (state_v[g]),
      .press      (press_v[g]),
      .rel        (rel_v[g]),
      .press_next (rise_v[g])
    );
  end

  // scan high to low so the lowest set index wins
  always_comb begin
    code_next = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (rise_v[i])
        code_next = CODE_W'(i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= |rise_v;
      code_q  <= code_next;
    end
  end

  assign bus.keyState   = state_v;
  assign bus.keyEdge    = press_v;
  assign bus.keyRelease = rel_v;
  assign bus.keyValid   = valid_q;
  assign bus.keyCode    = code_q;

endmodule

// File: tb/tb_multi_key_monitor.sv
// Scoreboard bench for multi_key_monitor at default parameters.
// Expected outputs are queued with a due cycle when keys change.
module tb_multi_key_monitor;

  localparam int LAT = 7;

  typedef struct {
    int          due;
    logic [14:0] exp;
    string       tag;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  bit   mon_en = 1'b0;
  logic [3:0] exp_state = 4'b0000;
  sb_t  sb[$];

  multi_key_monitor_if #(.NUM_KEYS(4), .CODE_W(2)) bus ();

  multi_key_monitor #(
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [14:0] pk(
    input logic [3:0] s, input logic [3:0] e,
    input logic [3:0] r, input logic v,
    input logic [1:0] c);
    return {s, e, r, v, c};
  endfunction

  task automatic check(input string tag,
                       input logic [14:0] obs,
                       input logic [14:0] exp);
    total++;
    if (obs === exp)
      passed++;
    else
      $display("FAIL %s @cyc %0d: got %h want %h",
               tag, cyc, obs, exp);
  endtask

  task automatic push(input string tag, input logic [14:0] e);
    sb_t t;
    t.due = cyc + LAT;
    t.exp = e;
    t.tag = tag;
    sb.push_back(t);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [14:0] obs;
  assign obs = {bus.keyState, bus.keyEdge, bus.keyRelease,
                bus.keyValid, bus.keyCode};

  sb_t cur;
  always @(negedge clock) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        cur = sb.pop_front();
        check(cur.tag, obs, cur.exp);
        exp_state = cur.exp[14:11];
      end else begin
        check("idle", obs, pk(exp_state, 4'b0, 4'b0, 1'b0, 2'd0));
      end
    end
  end

  initial begin
    bus.key = 4'b1111;
    reset   = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;
    wait_n(2);
    reset = 1'b0;
    wait_n(3);

    bus.key = 4'b1101;
    push("press1", pk(4'b0010, 4'b0010, 4'b0, 1'b1, 2'd1));
    wait_n(10);

    bus.key = 4'b1100;
    wait_n(3);
    bus.key = 4'b1101;
    wait_n(8);
    bus.key = 4'b1100;
    push("press0", pk(4'b0011, 4'b0001, 4'b0, 1'b1, 2'd0));
    wait_n(10);

    bus.key = 4'b0000;
    push("simul", pk(4'b1111, 4'b1100, 4'b0, 1'b1, 2'd2));
    wait_n(10);

    bus.key = 4'b0010;
    push("rel1", pk(4'b1101, 4'b0, 4'b0010, 1'b0, 2'd0));
    wait_n(10);

    bus.key = 4'b1111;
    push("rel_all", pk(4'b0000, 4'b0, 4'b1101, 1'b0, 2'd0));
    wait_n(10);

    bus.key = 4'b0111;
    wait_n(3);
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    push("rst_press", pk(4'b1000, 4'b1000, 4'b0, 1'b1, 2'd3));
    wait_n(12);

    mon_en = 1'b0;
    check("sb_empty", 15'(sb.size()), 15'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
